// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch-side types and constants for the JZJCoreF core.
package JZJCoreFPkg;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        FAULT      = 2'd2
    } FetchState;

    localparam logic [31:0] INSTRUCTION_NOP = 32'h00000013;
    localparam logic [31:0] PC_INCREMENT    = 32'd4;

    function automatic logic [31:0] alignWord(input logic [31:0] byteAddress);
        return {byteAddress[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_hold.sv
// Stall capture register: keeps the presented instruction and its PC while
// the decoder is stalled.
module fetch_hold_register (
    input  logic        clock,
    input  logic        reset,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] dataIn,
    input  logic [31:0] pcIn,
    output logic [31:0] heldInstruction,
    output logic [31:0] heldPC,
    output logic        heldValid
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            heldInstruction <= 32'h0;
            heldPC          <= 32'h0;
            heldValid       <= 1'b0;
        end else if (clear) begin
            heldValid <= 1'b0;
        end else if (capture) begin
            heldInstruction <= dataIn;
            heldPC          <= pcIn;
            heldValid       <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, issues word fetches, absorbs stalls/busy
// cycles and redirects. Misaligned-target trap: JZJCOREF_FETCH_MISALIGN_TRAP_EN.
//
//   state      | meaning
//   RESET_HOLD | reset asserted, or first cycle after release (fetches RESET_PC)
//   RUN        | normal sequential fetch
//   FAULT      | misaligned redirect trapped; left only by reset
module instruction_fetch_unit
    import JZJCoreFPkg::*;
#(
    parameter int          RAM_A_WIDTH = 12,
    parameter logic [31:0] RESET_PC    = 32'h00000000
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   fetchRequest,
    output logic [RAM_A_WIDTH-1:0] fetchAddress,
    input  logic [31:0]            fetchData,
    input  logic                   memBusy,
    input  logic                   stall,
    input  logic                   branchTaken,
    input  logic [31:0]            branchTarget,
    output logic [31:0]            instruction,
    output logic [31:0]            instructionPC,
    output logic                   instructionValid,
    output logic                   fault,
    output logic [31:0]            faultAddress
);

    FetchState   state, nextState;
    logic [31:0] pc, pendPC, nextPC, reqAddress, redirectAddress;
    logic        pendValid, loadPC, holdCapture, holdClear, misaligned, running;
    logic [31:0] heldInstruction, heldPC;
    logic        heldValid;

    assign redirectAddress = alignWord(branchTarget);
    assign reqAddress      = branchTaken ? redirectAddress : pc;
    // Gated by reset so the very first cycle after release already fetches.
    assign running         = reset & (state != FAULT);

`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
    assign misaligned = branchTaken & (branchTarget[1:0] != 2'b00);
`else
    logic unusedTargetLowBits;
    assign misaligned          = 1'b0;
    assign unusedTargetLowBits = ^branchTarget[1:0];
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= RESET_HOLD;
        else        state <= nextState;
    end

    always_comb begin
        nextState    = state;
        fetchRequest = 1'b0;
        loadPC       = 1'b0;
        nextPC       = pc;
        holdCapture  = 1'b0;
        holdClear    = 1'b0;
        case (state)
            RESET_HOLD, RUN: begin
                nextState = RUN;
                if (misaligned) begin
                    nextState = FAULT;
                    holdClear = 1'b1;
                end else begin
                    fetchRequest = running & ~memBusy & (~stall | branchTaken);
                    loadPC       = fetchRequest | branchTaken;
                    // A redirect blocked by memBusy parks the target in pc.
                    nextPC       = fetchRequest ? reqAddress + PC_INCREMENT : redirectAddress;
                    holdCapture  = stall & ~branchTaken & pendValid;
                    holdClear    = ~stall | branchTaken;
                end
            end
            FAULT:   holdClear = 1'b1;
            default: nextState = RESET_HOLD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc        <= RESET_PC;
            pendPC    <= 32'h0;
            pendValid <= 1'b0;
        end else begin
            pendValid <= fetchRequest;
            if (fetchRequest) pendPC <= reqAddress;
            if (loadPC)       pc     <= nextPC;
        end
    end

    fetch_hold_register holdReg (
        .clock          (clock),
        .reset          (reset),
        .capture        (holdCapture),
        .clear          (holdClear),
        .dataIn         (fetchData),
        .pcIn           (pendPC),
        .heldInstruction(heldInstruction),
        .heldPC         (heldPC),
        .heldValid      (heldValid)
    );

`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
    logic        faultFlag;
    logic [31:0] faultTarget;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            faultFlag   <= 1'b0;
            faultTarget <= 32'h0;
        end else if (running & misaligned) begin
            faultFlag   <= 1'b1;
            faultTarget <= branchTarget;
        end
    end

    assign fault        = faultFlag;
    assign faultAddress = faultTarget;
`else
    assign fault        = 1'b0;
    assign faultAddress = 32'h0;
`endif

    assign fetchAddress     = reqAddress[RAM_A_WIDTH+1:2];
    assign instructionValid = pendValid | heldValid;
    assign instruction      = pendValid ? fetchData
                            : (state == FAULT ? INSTRUCTION_NOP : heldInstruction);
    assign instructionPC    = pendValid ? pendPC : heldPC;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed test-plan scenarios
// followed by randomized stall/busy/redirect/reset traffic against a model.
module tb_instruction_fetch_unit;

    localparam int AW = 12;
`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          memBusy = 1'b0, stall = 1'b0, branchTaken = 1'b0;
    logic [31:0]   branchTarget = 32'h0;
    logic [31:0]   fetchData = 32'h0;
    logic          fetchRequest, instructionValid, fault;
    logic [AW-1:0] fetchAddress;
    logic [31:0]   instruction, instructionPC, faultAddress;

    instruction_fetch_unit #(.RAM_A_WIDTH(AW), .RESET_PC(32'h0)) dut (
        .clock           (clock),
        .reset           (reset),
        .fetchRequest    (fetchRequest),
        .fetchAddress    (fetchAddress),
        .fetchData       (fetchData),
        .memBusy         (memBusy),
        .stall           (stall),
        .branchTaken     (branchTaken),
        .branchTarget    (branchTarget),
        .instruction     (instruction),
        .instructionPC   (instructionPC),
        .instructionValid(instructionValid),
        .fault           (fault),
        .faultAddress    (faultAddress)
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clock) if (fetchRequest) fetchData <= mem[fetchAddress];

    // Model: what fetches next, and what the decoder sees (the presented
    // instruction is always the memory word at the presented PC).
    logic [31:0] mPC, mInstrPC, mFaultAddr;
    bit          mValid, mFault;
    int          checks = 0, failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mPC = 32'h0; mInstrPC = 32'h0; mFaultAddr = 32'h0; mValid = 0; mFault = 0;
    endtask

    task automatic step(input logic rr, input logic st, input logic mb,
                        input logic br, input logic [31:0] tgt);
        logic [31:0] addr;
        bit          expReq, mis;
        @(negedge clock);
        reset = rr; stall = st; memBusy = mb; branchTaken = br; branchTarget = tgt;
        #1;
        if (!rr) begin
            chk("rst_req", {31'b0, fetchRequest}, 32'h0);
            chk("rst_valid", {31'b0, instructionValid}, 32'h0);
            chk("rst_instr", instruction, 32'h0);
            chk("rst_pc", instructionPC, 32'h0);
            chk("rst_fault", {31'b0, fault}, 32'h0);
            modelReset();
            return;
        end
        mis    = !mFault && TRAP && br && (tgt[1:0] != 2'b00);
        addr   = br ? {tgt[31:2], 2'b00} : mPC;
        expReq = !mFault && !mis && !mb && (!st || br);
        chk("req", {31'b0, fetchRequest}, {31'b0, expReq});
        if (expReq) chk("addr", {20'b0, fetchAddress}, {20'b0, addr[AW+1:2]});
        chk("valid", {31'b0, instructionValid}, {31'b0, mValid});
        if (mValid) begin
            chk("ipc", instructionPC, mInstrPC);
            chk("instr", instruction, mem[mInstrPC[AW+1:2]]);
        end
        chk("fault", {31'b0, fault}, {31'b0, mFault});
        chk("faddr", faultAddress, mFault ? mFaultAddr : 32'h0);
        if (mFault) begin
        end else if (mis) begin
            mFault = 1; mFaultAddr = tgt; mValid = 0;
        end else if (expReq) begin
            mPC = addr + 32'd4; mValid = 1; mInstrPC = addr;
        end else if (br) begin
            mPC = addr; mValid = 0;
        end else if (!st) begin
            mValid = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[0] = 32'h00100093; mem[1] = 32'h00200113;
        mem[2] = 32'h00300193; mem[3] = 32'h00400213;
        modelReset();

        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 1, 32'h40);
        // reset release: cycle 0 fetches 0, cycles 1..4 present words 0..3
        step(1, 0, 0, 0, 0);
        chk("c0_req", {31'b0, fetchRequest}, 32'h1);
        chk("c0_addr", {20'b0, fetchAddress}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("c1_pc", instructionPC, 32'h0);
        chk("c1_instr", instruction, 32'h00100093);
        step(1, 0, 0, 0, 0);
        chk("c2_instr", instruction, 32'h00200113);
        for (int k = 0; k < 3; k++) begin
            step(1, 1, 0, 0, 0);
            chk("stall_instr", instruction, 32'h00300193);
            chk("stall_pc", instructionPC, 32'h8);
            chk("stall_noreq", {31'b0, fetchRequest}, 32'h0);
        end
        step(1, 0, 0, 0, 0);
        chk("unstall_valid", {31'b0, instructionValid}, 32'h1);
        chk("unstall_pc", instructionPC, 32'h8);
        chk("unstall_addr", {20'b0, fetchAddress}, 32'h3);
        step(1, 0, 0, 0, 0);
        chk("c7_pc", instructionPC, 32'hC);
        chk("c7_instr", instruction, 32'h00400213);
        step(1, 1, 0, 0, 0);
        // async reset mid-stall
        #1 reset = 1'b0;
        #1;
        chk("areset_valid", {31'b0, instructionValid}, 32'h0);
        chk("areset_req", {31'b0, fetchRequest}, 32'h0);
        chk("areset_instr", instruction, 32'h0);
        chk("areset_pc", instructionPC, 32'h0);
        modelReset();
        step(0, 0, 0, 0, 0);

        // redirect replaces the PC 4 fetch
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 32'h100);
        chk("br_addr", {20'b0, fetchAddress}, 32'h40);
        step(1, 0, 0, 0, 0);
        chk("br_pc", instructionPC, 32'h100);
        chk("br_valid", {31'b0, instructionValid}, 32'h1);
        // two busy cycles: two bubbles, then no skipped/repeated PC
        step(1, 0, 1, 0, 0);
        chk("mb_pc", instructionPC, 32'h104);
        step(1, 0, 1, 0, 0);
        chk("mb_bubble1", {31'b0, instructionValid}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("mb_bubble2", {31'b0, instructionValid}, 32'h0);
        chk("mb_addr", {20'b0, fetchAddress}, 32'h42);
        step(1, 0, 0, 0, 0);
        chk("mb_resume", instructionPC, 32'h108);

        step(1, 0, 0, 1, 32'h102);
`ifdef JZJCOREF_FETCH_MISALIGN_TRAP_EN
        chk("mis_noreq", {31'b0, fetchRequest}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("mis_fault", {31'b0, fault}, 32'h1);
        chk("mis_faddr", faultAddress, 32'h102);
        chk("mis_valid", {31'b0, instructionValid}, 32'h0);
        step(1, 0, 0, 0, 0);
        chk("mis_noreq2", {31'b0, fetchRequest}, 32'h0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
`else
        chk("mis_addr", {20'b0, fetchAddress}, 32'h40);
        step(1, 0, 0, 0, 0);
        chk("mis_pc", instructionPC, 32'h100);
        chk("mis_nofault", {31'b0, fault}, 32'h0);
`endif

        // PC wrap
        step(1, 0, 0, 1, 32'hFFFFFFFC);
        chk("wrap_addr_hi", {20'b0, fetchAddress}, 32'hFFF);
        step(1, 0, 0, 0, 0);
        chk("wrap_addr0", {20'b0, fetchAddress}, 32'h0);
        chk("wrap_pc_hi", instructionPC, 32'hFFFFFFFC);
        step(1, 0, 0, 0, 0);
        chk("wrap_pc0", instructionPC, 32'h0);
        chk("wrap_instr0", instruction, 32'h00100093);

        for (int n = 0; n < 3000; n++) begin
            logic        rr, st, mb, br;
            logic [31:0] tgt;
            rr  = !(mFault || $urandom_range(0, 199) == 0);
            st  = $urandom_range(0, 9) < 3;
            mb  = $urandom_range(0, 9) < 2;
            br  = $urandom_range(0, 9) == 0;
            tgt = $urandom;
            if ($urandom_range(0, 7) != 0) tgt[1:0] = 2'b00;
            step(rr, st, mb, br, tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetches 32-bit instruction words from the code/RAM port and presents them, with their PC, to `InstructionDecoder` in the `JZJCoreF` core. It owns the program counter, sequences PC+4 fetches, and applies branch/jump redirects from execute. It also absorbs stalls from downstream and busy cycles from the shared memory port. It sits directly upstream of the decoder's `instruction` input.

## Interface
- `RAM_A_WIDTH`, 12, word-address width of code/RAM.
- `RESET_PC`, 32'h00000000, first fetch address after reset.

- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `fetchRequest`  out  1  read strobe to synchronous RAM.
- `fetchAddress`  out  RAM_A_WIDTH  word address, equal to `pc[RAM_A_WIDTH+1:2]`.
- `fetchData`  in  32  RAM read data, valid the cycle after `fetchRequest`.
- `memBusy`  in  1  RAM port taken by load/store; suppresses the request.
- `stall`  in  1  downstream cannot accept; hold the current instruction.
- `branchTaken`  in  1  redirect strobe.
- `branchTarget`  in  32  redirect byte address.
- `instruction`  out  32  instruction to the decoder.
- `instructionPC`  out  32  byte address of `instruction`.
- `instructionValid`  out  1  `instruction` is live.
- `fault`  out  1  misaligned-target trap (sticky).
- `faultAddress`  out  32  offending target.

## Operation
- States: `RESET_HOLD` (reset asserted), `RUN`, `FAULT`.
- `RESET_HOLD` → `RUN` on the first rising edge with `reset` high.
- `RUN` → `FAULT` on a misaligned redirect (macro on only).
- `FAULT` is left only by reset.
- Registers:
  - `pc`: next address to fetch.
  - `pendPC`: address of the in-flight request.
  - `pendValid`: a request is in flight.
  - Hold register: instruction and PC.
  - `holdValid`.
- `fetchRequest` = `RUN & ~memBusy & (~stall | branchTaken)`.
- `fetchAddress` is the target's word address if `branchTaken`, else `pc`'s word address.
- Accepted request: `pc` ← address+4, `pendPC` ← address, `pendValid` ← 1.
- `pc` wraps from 32'hFFFFFFFC to 0. Address bits above `RAM_A_WIDTH+1` are ignored, so the word address wraps modulo 2^RAM_A_WIDTH.
- Output mux:
  - If `pendValid`, `instruction` = `fetchData` and `instructionPC` = `pendPC`.
  - Otherwise both come from the hold register.
- `instructionValid` = `pendValid | holdValid`.
- `stall` with a live response: capture `fetchData`/`pendPC` into the hold register, set `holdValid`, and issue no new request. Clear `holdValid` on the first non-stall cycle.
- `memBusy` without `stall`: no request, so a bubble (`instructionValid` = 0) next cycle.
- `branchTaken` beats `stall` and `memBusy`:
  - Kills the in-flight response and clears `holdValid`, so `instructionValid` = 0 in the following cycle unless the target fetch is issued.
  - If `memBusy`, latch the target into `pc` and fetch it when the port frees.
- Reset value of every output is 0; `instructionPC` is also 0.
- Reset asserted mid-fetch: outputs clear immediately and the returning `fetchData` is ignored.

## Timing
- Request in cycle N → `instructionValid`=1 with `fetchData` in cycle N+1.
- Sustained throughput is 1 instruction/cycle.
- First request: cycle 0, the first cycle with `reset` high, at `RESET_PC`.
- Redirect asserted in cycle N → target instruction valid in N+1, zero bubble.
- Stall lasting k cycles → the same instruction is held for k+1 cycles. The next request is issued in the cycle `stall` drops.

## Configuration
- `JZJCOREF_FETCH_MISALIGN_TRAP_EN`
- Defined: `branchTarget[1:0]`≠0 on a redirect enters `FAULT`.
  - `fault`=1 and `faultAddress`=target.
  - `fetchRequest` and `instructionValid` stay 0 until reset.
- Undefined: target bits [1:0] are forced to 0 and fetch continues; `fault`/`faultAddress` are tied 0.

## Structure
- Shared package `JZJCoreFPkg`:
  - `FetchState` enum.
  - `INSTRUCTION_NOP` (32'h00000013).
  - PC increment constant.
- One sub-module: `fetch_hold_register`, the stall capture register plus its valid bit.

## Test plan
- Reset release, RAM words 0..3 = 32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213 → cycles 1..4 present those words with PCs 0, 4, 8, 12, all valid.
- `stall` high for 3 cycles while PC 8 is presented → 32'h00300193/PC 8 held for 4 cycles, no `fetchRequest` during stall, PC 12 follows.
- `branchTaken` with target 32'h00000100 while PC 4 is in flight → PC 4 never valid, next valid instruction has PC 32'h100.
- `memBusy` for 2 cycles mid-stream → 2 bubbles, then sequence resumes with no PC skipped or repeated.
- Redirect to 32'h00000102 (macro on) → `fault`=1, `faultAddress`=32'h102, no further requests; async reset mid-stall clears all outputs immediately.
- PC 32'hFFFFFFFC fetched → next `fetchAddress` = 0, PC wraps to 0.
